// File: rtl/reveal_engine.sv
// Revealed-cell bitmap owner: single-cell reveal plus stack-based flood fill of zero-count regions.
// The mine map is read through an external port whose data arrives one cycle after the address.
`timescale 1ns/1ps
module reveal_engine #(
  parameter int GRID_W      = 16,
  parameter int GRID_H      = 16,
  parameter int NUM_MINES   = 40,
  parameter int STACK_DEPTH = 256,
  localparam int XW    = $clog2(GRID_W),
  localparam int YW    = $clog2(GRID_H),
  localparam int AW    = XW + YW,
  localparam int NCELL = GRID_W * GRID_H,
  localparam int CW    = $clog2(NCELL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] cursor_addr,
  input  logic          clear,
  output logic [AW-1:0] mine_rd_addr,
  input  logic          mine_rd_data,
  input  logic [AW-1:0] rev_rd_addr,
  output logic          rev_rd_data,
  output logic          busy,
  output logic          done,
  output logic          mine_hit,
  output logic          win,
  output logic [CW-1:0] revealed_cnt
);
  localparam int SW = $clog2(STACK_DEPTH);
  localparam logic [CW-1:0] THRESH = CW'(NCELL - NUM_MINES);
  localparam logic signed [XW:0] P1X = {{XW{1'b0}}, 1'b1};
  localparam logic signed [XW:0] M1X = {(XW+1){1'b1}};
  localparam logic signed [YW:0] P1Y = {{YW{1'b0}}, 1'b1};
  localparam logic signed [YW:0] M1Y = {(YW+1){1'b1}};

  typedef enum logic [2:0] {IDLE, CHK_RD, CHK, POP, CNT, SCAN, FIN} state_t;

  state_t          state;
  logic [NCELL-1:0] revealed;
  logic [AW-1:0]   stack [STACK_DEPTH];
  logic [SW:0]     sp, sp_m1;
  logic [AW-1:0]   cur, nb_addr, push_data;
  logic [3:0]      k, km1;
  logic [AW:0]     nb_cur, nb_prev;
  logic            has_mine, mine_seen, push_en;

  // Returns {in_bounds, addr}. With power-of-2 grids, stepping off either edge
  // sets the sign bit of the (XW+1)-bit signed coordinate, so the sign alone flags it.
  function automatic logic [AW:0] nb_calc(input logic [AW-1:0] a, input logic [2:0] idx);
    logic signed [XW:0] dx, nx;
    logic signed [YW:0] dy, ny;
    dx = '0;
    dy = '0;
    case (idx)
      3'd0: begin dx = M1X; dy = M1Y; end
      3'd1: begin dy = M1Y; end
      3'd2: begin dx = P1X; dy = M1Y; end
      3'd3: begin dx = M1X; end
      3'd4: begin dx = P1X; end
      3'd5: begin dx = M1X; dy = P1Y; end
      3'd6: begin dy = P1Y; end
      default: begin dx = P1X; dy = P1Y; end
    endcase
    nx = $signed({1'b0, a[XW-1:0]}) + dx;
    ny = $signed({1'b0, a[AW-1:XW]}) + dy;
    return {~nx[XW] & ~ny[YW], ny[YW-1:0], nx[XW-1:0]};
  endfunction

  always_comb begin
    km1      = k - 4'd1;
    nb_cur   = nb_calc(cur, k[2:0]);
    nb_prev  = nb_calc(cur, km1[2:0]);
    nb_addr  = nb_cur[AW-1:0];
    mine_rd_addr = (state == CNT && !k[3]) ? nb_addr : cur;
    // data seen in CNT belongs to the neighbour issued one step earlier
    mine_seen = (state == CNT) && (k != 4'd0) && nb_prev[AW] && mine_rd_data;
    push_en   = 1'b0;
    push_data = cur;
    if (state == CHK && !revealed[cur] && !mine_rd_data) push_en = 1'b1;
    if (state == SCAN && nb_cur[AW] && !revealed[nb_addr]) begin
      push_en   = 1'b1;
      push_data = nb_addr;
    end
  end

  assign rev_rd_data = revealed[rev_rd_addr];
  assign sp_m1       = sp - 1'b1;

  always_ff @(posedge clk)
    if (push_en) stack[sp[SW-1:0]] <= push_data;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state        <= IDLE;
      revealed     <= '0;
      sp           <= '0;
      revealed_cnt <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mine_hit     <= 1'b0;
      win          <= 1'b0;
      k            <= '0;
      has_mine     <= 1'b0;
      if (rst) cur <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !mine_hit && !win) begin
          cur   <= cursor_addr;
          busy  <= 1'b1;
          state <= CHK_RD;
        end
        CHK_RD: state <= CHK;
        CHK: begin
          if (revealed[cur]) state <= FIN;
          else begin
            revealed[cur] <= 1'b1;
            revealed_cnt  <= revealed_cnt + 1'b1;
            if (mine_rd_data) begin
              mine_hit <= 1'b1;
              state    <= FIN;
            end else begin
              if (revealed_cnt + 1'b1 == THRESH && !mine_hit) win <= 1'b1;
              sp    <= sp + 1'b1;
              state <= POP;
            end
          end
        end
        POP: begin
          if (sp == '0) state <= FIN;
          else begin
            cur      <= stack[sp_m1[SW-1:0]];
            sp       <= sp_m1;
            k        <= '0;
            has_mine <= 1'b0;
            state    <= CNT;
          end
        end
        CNT: begin
          if (mine_seen) has_mine <= 1'b1;
          if (k == 4'd8) begin
            k     <= '0;
            state <= (has_mine || mine_seen) ? POP : SCAN;
          end else k <= k + 4'd1;
        end
        SCAN: begin
          if (push_en) begin
            revealed[nb_addr] <= 1'b1;
            revealed_cnt      <= revealed_cnt + 1'b1;
            if (revealed_cnt + 1'b1 == THRESH && !mine_hit) win <= 1'b1;
            sp <= sp + 1'b1;
          end
          k <= k + 4'd1;
          if (k == 4'd7) state <= POP;
        end
        default: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reveal_engine.sv
// Directed bench for reveal_engine: mine-map model with 1-cycle read latency, per-scenario checks.
`timescale 1ns/1ps
module tb_reveal_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0, clear = 1'b0;
  logic [7:0] cursor_addr = '0, rev_rd_addr = '0, mine_rd_addr;
  logic       mine_rd_data, rev_rd_data, busy, done, mine_hit, win;
  logic [8:0] revealed_cnt;
  logic [255:0] mine_map = '0;
  int tests = 0, fails = 0;

  reveal_engine dut (
    .clk(clk), .rst(rst), .start(start), .cursor_addr(cursor_addr), .clear(clear),
    .mine_rd_addr(mine_rd_addr), .mine_rd_data(mine_rd_data),
    .rev_rd_addr(rev_rd_addr), .rev_rd_data(rev_rd_data),
    .busy(busy), .done(done), .mine_hit(mine_hit), .win(win), .revealed_cnt(revealed_cnt)
  );

  always_ff @(posedge clk) mine_rd_data <= mine_map[mine_rd_addr];

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [7:0] a);
    @(negedge clk); cursor_addr = a; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  // Edges after the start-sampling edge until done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    bit got = 0;
    lat = -1;
    for (int i = 1; i <= 20000 && !got; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; got = 1; end
    end
  endtask

  task automatic read_bitmap(output logic [255:0] bm);
    for (int i = 0; i < 256; i++) begin
      rev_rd_addr = 8'(i); #1;
      bm[i] = rev_rd_data;
    end
  endtask

  task automatic test_reset();
    logic [255:0] bm;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b exp 0", done); end
    tests++; if (mine_hit !== 1'b0 || win !== 1'b0) begin fails++; $display("FAIL reset_flags: got hit=%b win=%b exp 0 0", mine_hit, win); end
    tests++; if (revealed_cnt !== 9'd0) begin fails++; $display("FAIL reset_cnt: got %0d exp 0", revealed_cnt); end
    tests++; if (mine_rd_addr !== 8'h00) begin fails++; $display("FAIL reset_rd_addr: got %h exp 00", mine_rd_addr); end
    read_bitmap(bm);
    tests++; if (bm !== '0) begin fails++; $display("FAIL reset_bitmap: got %h exp 0", bm); end
  endtask

  task automatic test_empty_flood();
    int lat, extra = 0;
    logic [255:0] bm;
    mine_map = '0;
    pulse_clear();
    pulse_start(8'h00);
    wait_done(lat);
    tests++; if (lat < 0) begin fails++; $display("FAIL flood_timeout: got %0d exp done", lat); end
    repeat (6) begin @(posedge clk); #1; if (done) extra++; end
    tests++; if (extra !== 0) begin fails++; $display("FAIL flood_done_once: got %0d extra exp 0", extra); end
    tests++; if (revealed_cnt !== 9'd256) begin fails++; $display("FAIL flood_cnt: got %0d exp 256", revealed_cnt); end
    tests++; if (mine_hit !== 1'b0 || win !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL flood_flags: got hit=%b win=%b busy=%b exp 0 1 0", mine_hit, win, busy); end
    read_bitmap(bm);
    tests++; if (bm !== {256{1'b1}}) begin fails++; $display("FAIL flood_bitmap: got %h exp all ones", bm); end
  endtask

  task automatic test_single_mine();
    int lat;
    logic [255:0] bm, exp_bm;
    pulse_clear();
    mine_map = '0; mine_map[8'h11] = 1'b1;
    pulse_start(8'h00);
    wait_done(lat);
    tests++; if (lat !== 14) begin fails++; $display("FAIL single_latency: got %0d exp 14", lat); end
    tests++; if (revealed_cnt !== 9'd1) begin fails++; $display("FAIL single_cnt: got %0d exp 1", revealed_cnt); end
    exp_bm = '0; exp_bm[0] = 1'b1;
    read_bitmap(bm);
    tests++; if (bm !== exp_bm) begin fails++; $display("FAIL single_bitmap: got %h exp %h", bm, exp_bm); end
  endtask

  task automatic test_mine_hit();
    int lat;
    bit seen = 0;
    pulse_clear();
    mine_map = '0; mine_map[8'h55] = 1'b1;
    pulse_start(8'h55);
    wait_done(lat);
    tests++; if (lat !== 3) begin fails++; $display("FAIL hit_latency: got %0d exp 3", lat); end
    tests++; if (mine_hit !== 1'b1 || win !== 1'b0) begin fails++; $display("FAIL hit_flag: got hit=%b win=%b exp 1 0", mine_hit, win); end
    tests++; if (revealed_cnt !== 9'd1) begin fails++; $display("FAIL hit_cnt: got %0d exp 1", revealed_cnt); end
    rev_rd_addr = 8'h55; #1;
    tests++; if (rev_rd_data !== 1'b1) begin fails++; $display("FAIL hit_bit: got %b exp 1", rev_rd_data); end
    pulse_start(8'h00);
    repeat (12) begin @(posedge clk); #1; if (busy || done) seen = 1; end
    tests++; if (seen !== 1'b0 || revealed_cnt !== 9'd1) begin fails++; $display("FAIL hit_start_ignored: got active=%b cnt=%0d exp 0 1", seen, revealed_cnt); end
  endtask

  task automatic test_column();
    int lat;
    logic [255:0] bm, exp_bm;
    pulse_clear();
    mine_map = '0;
    for (int y = 0; y < 16; y++) mine_map[y*16+8] = 1'b1;
    pulse_start(8'h00);
    wait_done(lat);
    tests++; if (lat < 0) begin fails++; $display("FAIL column_timeout: got %0d exp done", lat); end
    tests++; if (revealed_cnt !== 9'd128) begin fails++; $display("FAIL column_cnt: got %0d exp 128", revealed_cnt); end
    tests++; if (mine_hit !== 1'b0 || win !== 1'b0) begin fails++; $display("FAIL column_flags: got hit=%b win=%b exp 0 0", mine_hit, win); end
    for (int a = 0; a < 256; a++) exp_bm[a] = ((a % 16) <= 7);
    read_bitmap(bm);
    tests++; if (bm !== exp_bm) begin fails++; $display("FAIL column_bitmap: got %h exp %h", bm, exp_bm); end
  endtask

  task automatic test_revealed_and_busy();
    int lat;
    logic [255:0] bm, exp_bm;
    pulse_start(8'h03);
    wait_done(lat);
    tests++; if (lat !== 3) begin fails++; $display("FAIL revealed_latency: got %0d exp 3", lat); end
    tests++; if (revealed_cnt !== 9'd128) begin fails++; $display("FAIL revealed_cnt: got %0d exp 128", revealed_cnt); end
    pulse_start(8'hFF);
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_asserted: got %b exp 1", busy); end
    pulse_start(8'h08);
    wait_done(lat);
    tests++; if (lat < 0) begin fails++; $display("FAIL busy_timeout: got %0d exp done", lat); end
    repeat (10) @(negedge clk);
    tests++; if (revealed_cnt !== 9'd240 || mine_hit !== 1'b0) begin fails++; $display("FAIL busy_ignored: got cnt=%0d hit=%b exp 240 0", revealed_cnt, mine_hit); end
    tests++; if (win !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL busy_win: got win=%b busy=%b exp 1 0", win, busy); end
    for (int a = 0; a < 256; a++) exp_bm[a] = ((a % 16) != 8);
    read_bitmap(bm);
    tests++; if (bm !== exp_bm) begin fails++; $display("FAIL right_bitmap: got %h exp %h", bm, exp_bm); end
  endtask

  task automatic test_clear_mid();
    int lat;
    logic [255:0] bm;
    pulse_clear();
    mine_map = '0;
    pulse_start(8'h00);
    repeat (100) @(negedge clk);
    tests++; if (busy !== 1'b1 || revealed_cnt === 9'd0) begin fails++; $display("FAIL mid_active: got busy=%b cnt=%0d exp 1 nonzero", busy, revealed_cnt); end
    clear = 1'b1; start = 1'b1; cursor_addr = 8'h22;
    @(negedge clk); clear = 1'b0; start = 1'b0;
    tests++; if (busy !== 1'b0 || done !== 1'b0 || revealed_cnt !== 9'd0) begin fails++; $display("FAIL mid_clear: got busy=%b done=%b cnt=%0d exp 0 0 0", busy, done, revealed_cnt); end
    read_bitmap(bm);
    tests++; if (bm !== '0 || busy !== 1'b0) begin fails++; $display("FAIL mid_bitmap: got %h busy=%b exp 0 0", bm, busy); end
    mine_map[8'h11] = 1'b1;
    pulse_start(8'h00);
    wait_done(lat);
    tests++; if (lat !== 14 || revealed_cnt !== 9'd1) begin fails++; $display("FAIL mid_restart: got lat=%0d cnt=%0d exp 14 1", lat, revealed_cnt); end
  endtask

  task automatic test_win();
    int lat;
    bit seen = 0;
    pulse_clear();
    for (int a = 0; a < 256; a++) mine_map[a] = (a >= 8'hE0) || (a >= 8'hD0 && a <= 8'hD7);
    tests++; if (win !== 1'b0) begin fails++; $display("FAIL win_cleared: got %b exp 0", win); end
    pulse_start(8'h00);
    wait_done(lat);
    tests++; if (lat < 0) begin fails++; $display("FAIL win_timeout: got %0d exp done", lat); end
    tests++; if (revealed_cnt !== 9'd216 || win !== 1'b1 || mine_hit !== 1'b0) begin fails++; $display("FAIL win_state: got cnt=%0d win=%b hit=%b exp 216 1 0", revealed_cnt, win, mine_hit); end
    pulse_start(8'hF0);
    repeat (12) begin @(posedge clk); #1; if (busy || done) seen = 1; end
    tests++; if (seen !== 1'b0 || mine_hit !== 1'b0) begin fails++; $display("FAIL win_start_ignored: got active=%b hit=%b exp 0 0", seen, mine_hit); end
  endtask

  initial begin
    test_reset();
    test_empty_flood();
    test_single_mine();
    test_mine_hit();
    test_column();
    test_revealed_and_busy();
    test_clear_mid();
    test_win();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
